// File: rtl/intra4x4_pred_mode_seq.sv
// intra4x4_pred_mode_seq: walks the Intra4x4 prediction-mode syntax of one macroblock
// (16 prev flags, a rem mode after every zero flag, optionally the chroma mode),
// strobes each decoded element to the mode decoder and tracks the MB position.
// Build option: define INTRA4X4_SEQ_CHROMA_EN to fetch intra_chroma_pred_mode before FIN.
module intra4x4_pred_mode_seq #(
    parameter int unsigned MB_W = 11,
    parameter int unsigned MB_H = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pic_start,
    input  logic       start,
    output logic       se_req,
    output logic [1:0] se_kind,
    input  logic       se_valid,
    input  logic [2:0] se_data,
    output logic [2:0] mb_pred_state,
    output logic [3:0] luma4x4BlkIdx,
    output logic       prev_intra4x4_pred_mode_flag,
    output logic [2:0] rem_intra4x4_pred_mode,
    output logic [1:0] intra_chroma_pred_mode,
    output logic [3:0] mb_num_h,
    output logic [3:0] mb_num_v,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] KIND_FLAG = 2'd0;
    localparam logic [1:0] KIND_REM  = 2'd1;
    localparam logic [2:0] STROBE_NONE = 3'd0;
    localparam logic [2:0] STROBE_FLAG = 3'd1;
    localparam logic [2:0] STROBE_REM  = 3'd2;
`ifdef INTRA4X4_SEQ_CHROMA_EN
    localparam logic [1:0] KIND_CHR   = 2'd2;
    localparam logic [2:0] STROBE_CHR = 3'd3;
`endif

    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(15);
    localparam logic [CNT_W-1:0] LAST_H   = CNT_W'(MB_W - 1);
    localparam logic [CNT_W-1:0] LAST_V   = CNT_W'(MB_H - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_FLAG,
        P_FLAG,
        W_REM,
        P_REM,
`ifdef INTRA4X4_SEQ_CHROMA_EN
        W_CHR,
        P_CHR,
`endif
        FIN
    } seqState_t;

    seqState_t state;

    // Sequencer FSM; every output is set together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                        <= IDLE;
            se_req                       <= 1'b0;
            se_kind                      <= KIND_FLAG;
            mb_pred_state                <= STROBE_NONE;
            luma4x4BlkIdx                <= '0;
            prev_intra4x4_pred_mode_flag <= 1'b0;
            rem_intra4x4_pred_mode       <= '0;
            busy                         <= 1'b0;
            done                         <= 1'b0;
        end else begin
            mb_pred_state <= STROBE_NONE;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= W_FLAG;
                        luma4x4BlkIdx <= '0;
                        se_req        <= 1'b1;
                        se_kind       <= KIND_FLAG;
                        busy          <= 1'b1;
                    end
                end
                W_FLAG: begin
                    if (se_valid) begin
                        prev_intra4x4_pred_mode_flag <= se_data[0];
                        state                        <= P_FLAG;
                        se_req                       <= 1'b0;
                        mb_pred_state                <= STROBE_FLAG;
                    end
                end
                W_REM: begin
                    if (se_valid) begin
                        rem_intra4x4_pred_mode <= se_data;
                        state                  <= P_REM;
                        se_req                 <= 1'b0;
                        mb_pred_state          <= STROBE_REM;
                    end
                end
                P_FLAG, P_REM: begin
                    if (state == P_FLAG && !prev_intra4x4_pred_mode_flag) begin
                        state   <= W_REM;
                        se_req  <= 1'b1;
                        se_kind <= KIND_REM;
                    end else if (luma4x4BlkIdx != LAST_BLK) begin
                        luma4x4BlkIdx <= luma4x4BlkIdx + CNT_W'(1);
                        state         <= W_FLAG;
                        se_req        <= 1'b1;
                        se_kind       <= KIND_FLAG;
                    end else begin
                        luma4x4BlkIdx <= '0;
`ifdef INTRA4X4_SEQ_CHROMA_EN
                        state   <= W_CHR;
                        se_req  <= 1'b1;
                        se_kind <= KIND_CHR;
`else
                        state <= FIN;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef INTRA4X4_SEQ_CHROMA_EN
                W_CHR: begin
                    if (se_valid) begin
                        state         <= P_CHR;
                        se_req        <= 1'b0;
                        mb_pred_state <= STROBE_CHR;
                    end
                end
                P_CHR: begin
                    state <= FIN;
                    done  <= 1'b1;
                end
`endif
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    se_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

`ifdef INTRA4X4_SEQ_CHROMA_EN
    // Chroma mode register, loaded on the accepted chroma element.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            intra_chroma_pred_mode <= '0;
        end else if (state == W_CHR && se_valid) begin
            intra_chroma_pred_mode <= se_data[1:0];
        end
    end
`else
    // No chroma element in this build.
    assign intra_chroma_pred_mode = 2'd0;
`endif

    // MB position counters; pic_start wins over the end-of-MB advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mb_num_h <= '0;
            mb_num_v <= '0;
        end else if (pic_start) begin
            mb_num_h <= '0;
            mb_num_v <= '0;
        end else if (state == FIN) begin
            if (mb_num_h == LAST_H) begin
                mb_num_h <= '0;
                mb_num_v <= (mb_num_v == LAST_V) ? '0 : mb_num_v + CNT_W'(1);
            end else begin
                mb_num_h <= mb_num_h + CNT_W'(1);
            end
        end
    end

endmodule
